// File: rtl/diffusion_pkg.sv
// Shared types and default sizing for the diffusion step scheduler and lane array.
package diffusion_pkg;

  localparam int unsigned NUM_LANES_DEFAULT      = 4;
  localparam int unsigned MAX_STEPS_DEFAULT      = 7;
  localparam int unsigned DATA_WIDTH_DEFAULT     = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 65535;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/diffusion_step_scheduler_if.sv
// PS control / lane array signal bundle for the diffusion step scheduler.
// The timeout signal exists only when STEP_TIMEOUT_EN is defined.
interface diffusion_step_scheduler_if #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  start;
  logic [NUM_LANES-1:0]  lane_en;
  logic [NUM_LANES-1:0]  finished;
  logic                  ack;
  logic [NUM_LANES-1:0]  lane_start;
  logic [DATA_WIDTH-1:0] l_step;
  logic                  busy;
  logic                  done;
`ifdef STEP_TIMEOUT_EN
  logic                  timeout;

  modport master (
    output start, lane_en, finished, ack,
    input  lane_start, l_step, busy, done, timeout
  );

  modport slave (
    input  start, lane_en, finished, ack,
    output lane_start, l_step, busy, done, timeout
  );
`else
  modport master (
    output start, lane_en, finished, ack,
    input  lane_start, l_step, busy, done
  );

  modport slave (
    input  start, lane_en, finished, ack,
    output lane_start, l_step, busy, done
  );
`endif

endinterface

// File: rtl/lane_done_collector.sv
// Sticky per-lane completion flags and the enable-masked all-done reduction.
module lane_done_collector
  import diffusion_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 cap_i,
  input  logic [NUM_LANES-1:0] en_i,
  input  logic [NUM_LANES-1:0] finished_i,
  output logic                 all_done_c_o
);

  logic [NUM_LANES-1:0] fin_q;
  logic [NUM_LANES-1:0] fin_d;

  // Clear on launch, otherwise accumulate enabled lanes' completions while capturing.
  always_comb begin
    fin_d = fin_q;
    if (clr_i) begin
      fin_d = '0;
    end else if (cap_i) begin
      fin_d = fin_q | (finished_i & en_i);
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_q <= '0;
    end else begin
      fin_q <= fin_d;
    end
  end

  // A lane counts as done if it reported earlier, reports now, or is disabled.
  assign all_done_c_o = &(fin_q | finished_i | ~en_i);

endmodule

// File: rtl/diffusion_step_scheduler.sv
// Sequences the diffusion lanes through up to MAX_STEPS propagation steps per query.
// Optional feature macro: STEP_TIMEOUT_EN adds a per-step WAIT watchdog and the timeout output.
module diffusion_step_scheduler
  import diffusion_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned NUM_LANES      = NUM_LANES_DEFAULT,
  parameter int unsigned MAX_STEPS      = MAX_STEPS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic                      clk,
  input logic                      rst,
  diffusion_step_scheduler_if.slave bus
);

  sched_state_t          state_q, state_d;
  logic [NUM_LANES-1:0]  en_q, en_d;
  logic [NUM_LANES-1:0]  lane_start_q, lane_start_d;
  logic [DATA_WIDTH-1:0] l_step_q, l_step_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fin_clr;
  logic                  fin_cap;
  logic                  all_done_c;

`ifdef STEP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  lane_done_collector #(
    .NUM_LANES (NUM_LANES)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (fin_clr),
    .cap_i        (fin_cap),
    .en_i         (en_q),
    .finished_i   (bus.finished),
    .all_done_c_o (all_done_c)
  );

  // Next-state logic; outputs are precomputed from the next state so they register cleanly.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    l_step_d = l_step_q;
    fin_clr  = 1'b0;
    fin_cap  = 1'b0;
`ifdef STEP_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && (|bus.lane_en)) begin
          en_d     = bus.lane_en;
          l_step_d = '0;
`ifdef STEP_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d  = (MAX_STEPS == 0) ? DONE : LAUNCH;
        end
      end

      LAUNCH: begin
        fin_clr = 1'b1;
`ifdef STEP_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        fin_cap = 1'b1;
`ifdef STEP_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (all_done_c) begin
          state_d = ADVANCE;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
`else
        if (all_done_c) begin
          state_d = ADVANCE;
        end
`endif
      end

      ADVANCE: begin
        l_step_d = l_step_q + DATA_WIDTH'(1);
        state_d  = (l_step_d == DATA_WIDTH'(MAX_STEPS)) ? DONE : LAUNCH;
      end

      DONE: begin
        if (bus.ack) begin
`ifdef STEP_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    lane_start_d = (state_d == LAUNCH) ? en_d : '0;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  // State and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      en_q         <= '0;
      l_step_q     <= '0;
      lane_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      l_step_q     <= l_step_d;
      lane_start_q <= lane_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef STEP_TIMEOUT_EN
  // Per-step watchdog counter and timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`endif

  assign bus.lane_start = lane_start_q;
  assign bus.l_step     = l_step_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_diffusion_step_scheduler.sv
// Directed bench for diffusion_step_scheduler: full runs, masked lanes, staggered
// completion, zero-step query, reset mid-run and (with STEP_TIMEOUT_EN) the watchdog.
module tb_diffusion_step_scheduler;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  diffusion_step_scheduler_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) ifa ();
  diffusion_step_scheduler_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) ifz ();

  diffusion_step_scheduler #(
    .DATA_WIDTH(DW), .NUM_LANES(NL), .MAX_STEPS(7), .TIMEOUT_CYCLES(16)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  diffusion_step_scheduler #(
    .DATA_WIDTH(DW), .NUM_LANES(NL), .MAX_STEPS(0), .TIMEOUT_CYCLES(16)
  ) u_z (
    .clk (clk),
    .rst (rst),
    .bus (ifz.slave)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the main instance's lane_start, l_step, busy and done.
  task automatic chk_a(input string tag, input logic [3:0] ls, input logic [31:0] st,
                       input logic b, input logic d);
    chk({tag, " lane_start"}, 32'(ifa.lane_start), 32'(ls));
    chk({tag, " l_step"},     ifa.l_step,          st);
    chk({tag, " busy"},       32'(ifa.busy),       32'(b));
    chk({tag, " done"},       32'(ifa.done),       32'(d));
  endtask

  // Seven-step query where lanes report 3 cycles after each launch pulse.
  task automatic run_query(input logic [3:0] en, input logic [3:0] fin);
    ifa.start   = 1'b1;
    ifa.lane_en = en;
    tick();
    ifa.start   = 1'b0;
    ifa.lane_en = 4'b1111;
    for (int s = 0; s < 7; s++) begin
      chk_a($sformatf("q%0h launch s%0d", en, s), en, 32'(s), 1'b1, 1'b0);
      tick();
      chk_a($sformatf("q%0h wait1 s%0d", en, s), 4'b0, 32'(s), 1'b1, 1'b0);
      tick();
      chk_a($sformatf("q%0h wait2 s%0d", en, s), 4'b0, 32'(s), 1'b1, 1'b0);
      tick();
      chk_a($sformatf("q%0h wait3 s%0d", en, s), 4'b0, 32'(s), 1'b1, 1'b0);
      ifa.finished = fin;
      tick();
      ifa.finished = '0;
      chk_a($sformatf("q%0h adv s%0d", en, s), 4'b0, 32'(s), 1'b1, 1'b0);
      tick();
    end
    chk_a($sformatf("q%0h done", en), 4'b0, 32'd7, 1'b1, 1'b1);
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;
    chk_a($sformatf("q%0h idle", en), 4'b0, 32'd7, 1'b0, 1'b0);
    tick();
    chk_a($sformatf("q%0h idle hold", en), 4'b0, 32'd7, 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    ifa.start    = 1'b0;
    ifa.lane_en  = '0;
    ifa.finished = '0;
    ifa.ack      = 1'b0;
    ifz.start    = 1'b0;
    ifz.lane_en  = '0;
    ifz.finished = '0;
    ifz.ack      = 1'b0;
    tick();
    tick();

    // Reset state of both instances.
    chk_a("reset", 4'b0, 32'd0, 1'b0, 1'b0);
    chk("reset z busy", 32'(ifz.busy), 32'd0);
    chk("reset z done", 32'(ifz.done), 32'd0);
`ifdef STEP_TIMEOUT_EN
    chk("reset timeout", 32'(ifa.timeout), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // All four lanes, then a masked lane set with the masked lanes silent.
    run_query(4'b1111, 4'b1111);
    run_query(4'b0101, 4'b0101);

    // Staggered completion: lane 0 at launch+2, lane 3 at launch+9.
    ifa.start   = 1'b1;
    ifa.lane_en = 4'b1001;
    tick();
    ifa.start = 1'b0;
    chk_a("stag launch", 4'b1001, 32'd0, 1'b1, 1'b0);
    ifa.finished = 4'b1001;  // reported during launch: must be discarded
    tick();
    ifa.finished = '0;
    chk_a("stag c2", 4'b0, 32'd0, 1'b1, 1'b0);
    tick();
    ifa.finished = 4'b0001;
    tick();
    ifa.finished = '0;
    for (int c = 4; c < 10; c++) begin
      chk_a($sformatf("stag c%0d", c), 4'b0, 32'd0, 1'b1, 1'b0);
      tick();
    end
    chk_a("stag c10", 4'b0, 32'd0, 1'b1, 1'b0);
    ifa.finished = 4'b1000;
    tick();
    ifa.finished = '0;
    chk_a("stag adv", 4'b0, 32'd0, 1'b1, 1'b0);
    tick();
    chk_a("stag relaunch", 4'b1001, 32'd1, 1'b1, 1'b0);

    // Fast steps up to l_step=4, then reset in WAIT.
    for (int s = 1; s < 4; s++) begin
      tick();
      ifa.finished = 4'b1001;
      tick();
      ifa.finished = '0;
      chk_a($sformatf("fast adv s%0d", s), 4'b0, 32'(s), 1'b1, 1'b0);
      tick();
      chk_a($sformatf("fast launch s%0d", s + 1), 4'b1001, 32'(s + 1), 1'b1, 1'b0);
    end
    tick();
    chk_a("pre-rst wait", 4'b0, 32'd4, 1'b1, 1'b0);
    rst          = 1'b1;
    ifa.finished = 4'b1001;
    ifa.start    = 1'b1;
    ifa.lane_en  = 4'b1111;
    tick();
    rst       = 1'b0;
    ifa.start = 1'b0;
    chk_a("mid rst", 4'b0, 32'd0, 1'b0, 1'b0);
    tick();
    ifa.finished = '0;
    chk_a("late finished", 4'b0, 32'd0, 1'b0, 1'b0);

    // Restart after reset, then truncate the launch pulse with reset.
    ifa.start   = 1'b1;
    ifa.lane_en = 4'b1111;
    tick();
    ifa.start = 1'b0;
    chk_a("restart launch", 4'b1111, 32'd0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_a("launch rst", 4'b0, 32'd0, 1'b0, 1'b0);

    // start with an empty mask is ignored.
    ifa.start   = 1'b1;
    ifa.lane_en = 4'b0000;
    tick();
    ifa.start = 1'b0;
    chk_a("empty mask", 4'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk_a("empty mask hold", 4'b0, 32'd0, 1'b0, 1'b0);

    // Zero-step query goes straight to DONE.
    ifz.start   = 1'b1;
    ifz.lane_en = 4'b0011;
    tick();
    ifz.start = 1'b0;
    ifz.ack   = 1'b1;
    chk("z done",       32'(ifz.done),       32'd1);
    chk("z busy",       32'(ifz.busy),       32'd1);
    chk("z lane_start", 32'(ifz.lane_start), 32'd0);
    chk("z l_step",     ifz.l_step,          32'd0);
    tick();
    ifz.ack = 1'b0;
    chk("z idle done",  32'(ifz.done),       32'd0);
    chk("z idle busy",  32'(ifz.busy),       32'd0);
    chk("z idle ls",    32'(ifz.lane_start), 32'd0);

`ifdef STEP_TIMEOUT_EN
    // Lane 2 never reports: watchdog fires after 16 WAIT cycles.
    ifa.start   = 1'b1;
    ifa.lane_en = 4'b0111;
    tick();
    ifa.start = 1'b0;
    chk_a("to launch", 4'b0111, 32'd0, 1'b1, 1'b0);
    tick();
    ifa.finished = 4'b0011;
    for (int c = 2; c < 18; c++) begin
      chk_a($sformatf("to wait c%0d", c), 4'b0, 32'd0, 1'b1, 1'b0);
      chk($sformatf("to wait c%0d timeout", c), 32'(ifa.timeout), 32'd0);
      tick();
      ifa.finished = '0;
    end
    chk_a("to done", 4'b0, 32'd0, 1'b1, 1'b1);
    chk("to timeout", 32'(ifa.timeout), 32'd1);
    ifa.ack = 1'b1;
    tick();
    ifa.ack = 1'b0;
    chk_a("to ack", 4'b0, 32'd0, 1'b0, 1'b0);
    chk("to ack timeout", 32'(ifa.timeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
